tmds_encoder_mc: RTL
====================

Name: tmds_encoder_mc

Overview:
- Pipelined, multi-channel TMDS encoder for the HDMI/DVI output path.
- Takes per-channel 8-bit pixel data, 2-bit control and 4-bit auxiliary nibbles, and emits 10-bit symbols, one per channel, to the serialiser.
- Per-channel stages: transition minimisation, then DC balancing with a running disparity counter. Also produces control, TERC4 data-island and video guard-band symbols.
- Channel count and pipeline registers are parametrised.

Parameters:
- NUM_CH, 3: number of independent TMDS channels; channel i uses slice [i*W+:W] of every packed port.
- OUT_REG, 1: 1 adds an output register (latency 2); 0 drives the stage-2 result combinationally (latency 1).

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- valid_in  input  1  qualifies all inputs this cycle.
- mode_in  input  2  0 CTRL, 1 VIDEO, 2 TERC4, 3 GUARD; common to all channels.
- data_in  input  8*NUM_CH  pixel bytes.
- ctrl_in  input  2*NUM_CH  {C1,C0} per channel.
- aux_in  input  4*NUM_CH  TERC4 nibble per channel.
- tmds_out  output  10*NUM_CH  encoded symbols, bit 0 transmitted first.
- valid_out  output  1  tmds_out is valid.

Behaviour:
- Reset: asserting rst_n_in low immediately clears all pipeline registers, valid flags and disparity counters.
  - tmds_out = 0 and valid_out = 0 while reset is held and after release until the first valid symbol.
  - Reset mid-stream discards all in-flight symbols.
- Pipeline:
  - Stage 1 registers q_m[8:0], N1/N0 of q_m[7:0], mode and the valid flag.
  - Stage 2 (plus the optional output register) produces the symbol.
  - valid_out follows valid_in by exactly 2 cycles (OUT_REG=1). There is no backpressure.
  - Cycles with valid_in=0 propagate as bubbles. Bubbles leave the counter unchanged and do not update tmds_out (it holds its last value).
- Stage 1, transition minimisation:
  - n = popcount(data).
  - XNOR chain (q_m[8]=0) if n>4 or (n==4 and data[0]==0); otherwise XOR chain (q_m[8]=1).
  - q_m[0] = data[0]; q_m[k] = q_m[k-1] XOR/XNOR data[k].
- Stage 2, VIDEO mode: cnt is a 6-bit signed value per channel.
  - Case A, cnt==0 or N1==N0:
    - out[9] = ~q_m[8], out[8] = q_m[8].
    - out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + N0 - N1.
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += N1 - N0 - 2*(~q_m[8]).
- Stage 2, non-VIDEO modes: any valid CTRL, TERC4 or GUARD symbol forces cnt to 0.
  - CTRL {C1,C0}: 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
  - TERC4: aux nibble mapped through the 16-entry HDMI 1.4 TERC4 table.
  - GUARD: channel 1 → 10'b0100110011; all other channels → 10'b1011001100.
- Mode may change on any valid cycle.
  - The first VIDEO symbol after a non-VIDEO symbol starts from cnt=0.
  - Mode travels with its data; there is no cross-cycle mixing.
- All channels are independent. Each has its own counter.

Decomposition:
- Package tmds_pkg holds:
  - mode enum (CTRL, VIDEO, TERC4, GUARD);
  - the four control tokens;
  - the two guard tokens;
  - TERC4 table as a 16x10 constant array;
  - popcount8 function.
- Sub-module tmds_channel holds stage 1 and 2 plus the counter for one channel.
  - Top level generates NUM_CH instances and the shared valid/mode pipeline.

Test Plan:
- Reset then mode CTRL, ctrl_in ch0 = 2'b00, valid_in=1 → 2 cycles later tmds_out[9:0] = 10'b1101010100, valid_out=1.
- VIDEO, data 0x00 twice from cnt=0 → symbols 10'h100 (cnt=-8), then 10'h3FF (cnt=+2).
- VIDEO, data 0xFF from cnt=0 → 10'h200, cnt=-8.
- GUARD for NUM_CH=3 → ch0/ch2 = 10'b1011001100, ch1 = 10'b0100110011; next VIDEO 0x00 → 10'h100 (counter was cleared).
- TERC4 sweep of aux 0..15 on every channel → each symbol matches the table; valid_in toggled 1,0,1 → valid_out shows 1,0,1 two cycles later, and the bubble holds tmds_out.
- Drop rst_n_in asynchronously mid-stream with cnt≠0 → outputs clear without a clock edge; first VIDEO 0x00 after release → 10'h100.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol modes, fixed control/guard tokens,
// the TERC4 data-island table and a byte popcount helper.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GUARD = 2'd3
    } tmds_mode_e;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_TOKEN_CH1   = 10'b0100110011;
    localparam logic [9:0] GUARD_TOKEN_OTHER = 10'b1011001100;

    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS lane: stage-1 transition minimisation register, stage-2 DC
// balancing with its own running disparity, plus non-video token selection.
module tmds_channel
    import tmds_pkg::*;
#(
    parameter int CH_IDX  = 0,
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    input  logic [1:0] ctrl_i,
    input  logic [3:0] aux_i,
    input  logic       s1_valid_i,
    input  tmds_mode_e s1_mode_i,
    output logic [9:0] sym_o
);

    logic [3:0] n_data;
    logic       use_xnor;
    logic [8:0] qm_d;
    logic [3:0] n1_d;

    logic [8:0] qm_q;
    logic [3:0] n1_q;
    logic [3:0] n0_q;
    logic [1:0] ctrl_q;
    logic [3:0] aux_q;

    logic signed [5:0] cnt_q;
    logic signed [5:0] cnt_d;
    logic signed [5:0] diff;
    logic              cnt_pos;
    logic              cnt_neg;
    logic [9:0]        sym_d;
    logic [9:0]        last_q;

    // XNOR is XOR with an extra inversion per step, so one accumulator covers both chains.
    always_comb begin
        logic acc;
        n_data   = popcount8(data_i);
        use_xnor = (n_data > 4'd4) || ((n_data == 4'd4) && !data_i[0]);
        acc      = data_i[0];
        qm_d     = '0;
        qm_d[0]  = acc;
        for (int k = 1; k < 8; k++) begin
            acc     = acc ^ data_i[k] ^ use_xnor;
            qm_d[k] = acc;
        end
        qm_d[8] = ~use_xnor;
        n1_d    = popcount8(qm_d[7:0]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            qm_q   <= '0;
            n1_q   <= '0;
            n0_q   <= '0;
            ctrl_q <= '0;
            aux_q  <= '0;
        end else if (valid_i) begin
            qm_q   <= qm_d;
            n1_q   <= n1_d;
            n0_q   <= 4'd8 - n1_d;
            ctrl_q <= ctrl_i;
            aux_q  <= aux_i;
        end
    end

    always_comb begin
        diff    = $signed({2'b00, n1_q}) - $signed({2'b00, n0_q});
        cnt_pos = !cnt_q[5] && (cnt_q != 6'sd0);
        cnt_neg = cnt_q[5];
        sym_d   = '0;
        cnt_d   = cnt_q;
        unique case (s1_mode_i)
            MODE_VIDEO: begin
                if ((cnt_q == 6'sd0) || (n1_q == n0_q)) begin
                    sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                end else if ((cnt_pos && (n1_q > n0_q)) || (cnt_neg && (n0_q > n1_q))) begin
                    sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d = cnt_q - diff + (qm_q[8] ? 6'sd2 : 6'sd0);
                end else begin
                    sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d = cnt_q + diff - (qm_q[8] ? 6'sd0 : 6'sd2);
                end
            end
            MODE_CTRL: begin
                cnt_d = '0;
                unique case (ctrl_q)
                    2'b00:   sym_d = CTRL_TOKEN_00;
                    2'b01:   sym_d = CTRL_TOKEN_01;
                    2'b10:   sym_d = CTRL_TOKEN_10;
                    default: sym_d = CTRL_TOKEN_11;
                endcase
            end
            MODE_TERC4: begin
                cnt_d = '0;
                sym_d = TERC4_TABLE[aux_q];
            end
            MODE_GUARD: begin
                cnt_d = '0;
                sym_d = (CH_IDX == 1) ? GUARD_TOKEN_CH1 : GUARD_TOKEN_OTHER;
            end
        endcase
    end

    // last_q doubles as the output register and as the bubble-hold value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else if (s1_valid_i) begin
            cnt_q  <= cnt_d;
            last_q <= sym_d;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            assign sym_o = last_q;
        end else begin : g_out_comb
            assign sym_o = s1_valid_i ? sym_d : last_q;
        end
    endgenerate

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS encoder: shared valid/mode pipeline feeding NUM_CH
// independent lanes; symbols appear 2 cycles after input (1 without OUT_REG).
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter bit OUT_REG = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   valid_in,
    input  logic [1:0]             mode_in,
    input  logic [8*NUM_CH-1:0]    data_in,
    input  logic [2*NUM_CH-1:0]    ctrl_in,
    input  logic [4*NUM_CH-1:0]    aux_in,
    output logic [10*NUM_CH-1:0]   tmds_out,
    output logic                   valid_out
);

    logic       s1_valid_q;
    tmds_mode_e s1_mode_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_CTRL;
        end else begin
            s1_valid_q <= valid_in;
            if (valid_in) begin
                s1_mode_q <= tmds_mode_e'(mode_in);
            end
        end
    end

    generate
        if (OUT_REG) begin : g_valid_reg
            logic s2_valid_q;
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                end
            end
            assign valid_out = s2_valid_q;
        end else begin : g_valid_comb
            assign valid_out = s1_valid_q;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            tmds_channel #(
                .CH_IDX  (gi),
                .OUT_REG (OUT_REG)
            ) u_ch (
                .clk_i      (clk_in),
                .rst_n_i    (rst_n_in),
                .valid_i    (valid_in),
                .data_i     (data_in[gi*8 +: 8]),
                .ctrl_i     (ctrl_in[gi*2 +: 2]),
                .aux_i      (aux_in[gi*4 +: 4]),
                .s1_valid_i (s1_valid_q),
                .s1_mode_i  (s1_mode_q),
                .sym_o      (tmds_out[gi*10 +: 10])
            );
        end
    endgenerate

endmodule
